// File: rtl/mul32_seq_if.sv
// Request/result bundle between the execute-stage controller and the sequential multiplier.
interface mul32_seq_if #(
  parameter int unsigned Width = 32
);
  logic             start;
  logic             sign_mode;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             busy;
  logic             done;
  logic [Width-1:0] hi;
  logic [Width-1:0] lo;

  modport master (
    output start, sign_mode, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sign_mode, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul32_seq.sv
// Multi-cycle shift-and-add multiplier. Operands are reduced to magnitudes at start,
// multiplied unsigned one bit per clock, then the sign is reapplied in a single fix-up step.
module mul32_seq #(
  parameter int unsigned Width = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  mul32_seq_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [Width-1:0]   OneW   = 1;
  localparam logic [2*Width-1:0] OneP   = 1;
  localparam logic [CntW-1:0]    CntOne = 1;
  localparam logic [CntW-1:0]    CntMax = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] mag_a_q, mag_a_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width:0]   acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;

  logic [Width:0]   sum_ext;
  logic [2*Width-1:0] prod;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mag_a_q <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state and datapath step for the current FSM state.
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum_ext = '0;
    prod    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          // Magnitude of the most negative value is still representable unsigned.
          mag_a_d = (bus_io.sign_mode && bus_io.a[Width-1]) ? (~bus_io.a + OneW) : bus_io.a;
          q_d     = (bus_io.sign_mode && bus_io.b[Width-1]) ? (~bus_io.b + OneW) : bus_io.b;
          neg_d   = bus_io.sign_mode & (bus_io.a[Width-1] ^ bus_io.b[Width-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end

      StCalc: begin
        sum_ext = {1'b0, acc_q[Width-1:0]} + {1'b0, (q_q[0] ? mag_a_q : '0)};
        // Shift {carry, sum, q} right by one; the low product bits migrate into q.
        {acc_d, q_d} = {1'b0, sum_ext, q_q[Width-1:1]};
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntMax) begin
          state_d = StFix;
        end
      end

      StFix: begin
        prod = {acc_q[Width-1:0], q_q};
        if (neg_q) begin
          prod = ~prod + OneP;
        end
        hi_d    = prod[2*Width-1:Width];
        lo_d    = prod[Width-1:0];
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and result outputs decoded from registered state.
  always_comb begin
    bus_io.busy = (state_q == StCalc) || (state_q == StFix);
    bus_io.done = (state_q == StDone);
    bus_io.hi   = hi_q;
    bus_io.lo   = lo_q;
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Directed and randomised checks of the sequential multiplier with a result scoreboard.
module tb_mul32_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul32_seq_if #(.Width(32)) bus ();

  mul32_seq #(.Width(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  logic [63:0] sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic sm, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] pa, pb;
    pa = sm ? {{32{a[31]}}, a} : {32'b0, a};
    pb = sm ? {{32{b[31]}}, b} : {32'b0, b};
    return pa * pb;
  endfunction

  // Drive one request across a single clock edge; optionally record its expected result.
  task automatic issue(input logic sm, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    @(negedge clk);
    bus.sign_mode = sm;
    bus.a         = a;
    bus.b         = b;
    bus.start     = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Wait for done after the start edge, checking latency, result and pulse width.
  task automatic finish_op(input string tag, input int poke_at);
    int          lat;
    logic [63:0] exp;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check({tag, " busy"}, 64'(bus.busy), 64'd1);
      if (k == 5) check({tag, " hold"}, {bus.hi, bus.lo}, last_res);
      if (k == poke_at) begin
        bus.start     = 1'b1;
        bus.a         = 32'd2;
        bus.b         = 32'd2;
        bus.sign_mode = ~bus.sign_mode;
      end else if (poke_at > 0 && k == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy@done"}, 64'(bus.busy), 64'd0);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = 'x;
    check({tag, " result"}, {bus.hi, bus.lo}, exp);
    last_res = exp;
    @(posedge clk);
    #1;
    check({tag, " pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.sign_mode = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b1);
    finish_op("u3x5", 0);

    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
    finish_op("umax", 0);

    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b1);
    finish_op("sm1xm1", 0);

    issue(1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b1);
    finish_op("sm3x5", 0);

    issue(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1);
    finish_op("sminsq", 0);

    issue(1'b1, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000, 1'b1);
    finish_op("sminx1", 0);

    // Start pulse and operand changes mid-operation must be ignored.
    issue(1'b0, 32'd7, 32'd9, 64'h00000000_0000003F, 1'b1);
    finish_op("ignore", 10);
    bus.a = '0;
    bus.b = '0;

    for (int i = 0; i < 4; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      issue(rs, ra, rb, model(rs, ra, rb), 1'b1);
      finish_op("rand", 0);
    end

    // Reset between edges aborts the operation with no done pulse.
    issue(1'b0, 32'h12345678, 32'h9ABCDEF0, 64'd0, 1'b0);
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort nodone", 64'(bus.done), 64'd0);
    end
    @(negedge clk);
    rst      = 1'b0;
    last_res = '0;
    @(posedge clk);
    #1;
    check("post-reset done", 64'(bus.done), 64'd0);

    issue(1'b0, 32'd0, 32'hFFFFFFFF, 64'd0, 1'b1);
    finish_op("zero", 0);

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul32_seq.md
Name: mul32_seq

Overview:
- Multi-cycle 32x32 shift-and-add multiplier for the CPU execute stage.
- Sits directly downstream of the 33-bit adder (A + B + C0 -> S[32:0]) and consumes its carry-out sum once per cycle; one add/shift step per clock.
- Produces a 64-bit product in HI/LO for MULT/MULTU, with a start/busy/done handshake to the controller.

Parameters:
- WIDTH, 32, operand width. Product is 2*WIDTH. Iteration count equals WIDTH. Only 32 is verified.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sign_mode  input  1  1 = signed (MULT), 0 = unsigned (MULTU); latched with start
- A  input  32  multiplicand; latched with start
- B  input  32  multiplier; latched with start
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; HI/LO valid from this cycle
- HI  output  32  product[63:32]
- LO  output  32  product[31:0]

Behaviour:
- Reset (async, any state): state = IDLE; busy = 0, done = 0, HI = 0, LO = 0; all internal registers cleared. An operation in flight is abandoned with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = 1 at edge t0 latches mag_a = |A| and mag_b = |B| when sign_mode = 1, else raw A and B.
  - Also latches neg = sign_mode & (A[31] ^ B[31]) and clears acc[32:0] and count.
  - Next state is CALC.
- Magnitude: ~x + 1 (33-bit add with C0 = 1). 0x80000000 maps to magnitude 0x80000000, which fits unsigned.
- CALC, one step per edge t1..t32:
  - {c, sum} = acc[31:0] + (q[0] ? mag_a : 0), a 33-bit add with C0 = 0, where q is the multiplier shift register.
  - Shift right: {acc, q} <= {c, sum, q} >> 1.
  - count increments. At edge t32 (count == 31), next state is FIX.
- FIX, edge t33:
  - product = {acc[31:0], q}.
  - If neg, product = ~product + 1 (64-bit).
  - Write HI/LO. Next state is DONE.
- DONE:
  - done = 1 for exactly one cycle (the cycle after t33). busy = 0.
  - Next state is IDLE.
- Latency: done is seen 33 edges after the start edge, fixed regardless of operand values (zero operands included).
- busy = 1 during CALC and FIX (edges t0+ through t33).
- start is ignored in CALC, FIX and DONE. No queuing; the controller must wait for done.
- A, B and sign_mode changes after t0 have no effect on the result.
- HI/LO hold their last result until the next FIX write. They are not cleared by a new start.
- Back-to-back: start held high from DONE is accepted on the first IDLE cycle.
- Unsigned products never overflow 64 bits. Signed results are exact two's complement; there is no overflow flag.

Test Plan:
- Reset, then unsigned A = 3, B = 5 -> done pulses exactly 33 edges after start and for one cycle only; HI = 0x00000000, LO = 0x0000000F; busy low when done is high.
- Unsigned A = B = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. Signed same operands -> HI = 0x00000000, LO = 0x00000001.
- Signed A = 0xFFFFFFFD (-3), B = 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Signed A = 0x80000000, B = 0x80000000 -> HI = 0x40000000, LO = 0x00000000. Signed A = 0x80000000, B = 1 -> HI = 0xFFFFFFFF, LO = 0x80000000.
- Start 7 x 9 unsigned; at cycle 10, pulse start with new A = 2, B = 2 and change A/B -> request ignored; result HI = 0, LO = 63, done only once.
- Start 0x12345678 x 0x9ABCDEF0; assert rst at cycle 15 between clock edges -> outputs zero immediately, busy = 0, no done pulse. Then 0 x 0xFFFFFFFF -> HI = LO = 0 with the same 33-edge latency.
